// File: rtl/parking_pkg.sv
// Shared parking-lot types and constants: gate FSM states, default capacity and hold time.
// Also used by the display and fee blocks, so changes here ripple beyond the gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    HOLD     = 2'd3
  } gate_state_t;

  localparam int DEFAULT_CAPACITY    = 16;
  localparam int OPEN_SEC            = 5;
  localparam int DEFAULT_TIMEOUT_SEC = 30;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchroniser plus registered rising-edge detect; pulse appears 3 clk cycles after the input rises.
// No backpressure: one pulse per input rising edge, regardless of downstream state.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier gate FSM with occupancy tracking; gate_open follows a request by one clk_in cycle, no backpressure.
// Optional timeout alarm compiled in with GATE_TIMEOUT_EN.
module parking_gate_ctrl #(
  parameter int CAPACITY    = parking_pkg::DEFAULT_CAPACITY,
  parameter int OPEN_SEC    = parking_pkg::OPEN_SEC,
`ifdef GATE_TIMEOUT_EN
  parameter int TIMEOUT_SEC = parking_pkg::DEFAULT_TIMEOUT_SEC,
`endif
  parameter int CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sec_clk,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_sensor,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             alarm
);

  import parking_pkg::*;

  localparam int               HOLD_W    = $clog2(OPEN_SEC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OPEN_SEC);
  localparam logic [CNT_W-1:0]  CAP_VAL   = CNT_W'(CAPACITY);

  gate_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              seen;
  logic              pass_d;
  logic              sec_tick;
  logic              car_clear;
  logic [CNT_W-1:0]  occ_next;

`ifdef GATE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_SEC + 1);
  logic [WAIT_W-1:0] wait_cnt;
`else
  assign alarm = 1'b0;
`endif

  sync_edge_det u_sec_sync (
    .clk      (clk_in),
    .rst      (rst),
    .async_in (sec_clk),
    .pulse    (sec_tick)
  );

  // A car counts only once it has been seen under the barrier and then leaves it.
  assign car_clear = seen & pass_d & ~pass_sensor;

  always_comb begin
    occ_next = occupancy;
    if (state == OPEN_IN && occupancy != CAP_VAL) begin
      occ_next = occupancy + 1'b1;
    end else if (state == OPEN_OUT && occupancy != '0) begin
      occ_next = occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gate_open <= 1'b0;
      occupancy <= '0;
      full      <= 1'b0;
      hold_cnt  <= '0;
      seen      <= 1'b0;
      pass_d    <= 1'b0;
`ifdef GATE_TIMEOUT_EN
      wait_cnt  <= '0;
      alarm     <= 1'b0;
`endif
    end else begin
      pass_d <= pass_sensor;
      case (state)
        IDLE: begin
          seen <= 1'b0;
`ifdef GATE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (exit_req) begin
            state     <= OPEN_OUT;
            gate_open <= 1'b1;
          end else if (entry_req && !full) begin
            state     <= OPEN_IN;
            gate_open <= 1'b1;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (pass_sensor) seen <= 1'b1;
          // A clear on the same cycle as a tick wins; the tick is simply dropped.
          if (car_clear) begin
            occupancy <= occ_next;
            full      <= (occ_next == CAP_VAL);
            hold_cnt  <= HOLD_LOAD;
            state     <= HOLD;
`ifdef GATE_TIMEOUT_EN
            alarm     <= 1'b0;
          end else if (!seen && sec_tick) begin
            if (wait_cnt == WAIT_W'(TIMEOUT_SEC - 1)) begin
              alarm    <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
`endif
          end
        end
        HOLD: begin
          if (pass_sensor) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state     <= IDLE;
            gate_open <= 1'b0;
          end else if (sec_tick) begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: scoreboard of expected outputs pushed with each stimulus step.
// Handles both builds of GATE_TIMEOUT_EN.
module tb_parking_gate_ctrl;

  localparam int CAP  = 16;
  localparam int HOLD = 5;
  localparam int TMO  = 30;
  localparam int CW   = $clog2(CAP + 1);

  logic          clk_in      = 1'b0;
  logic          rst         = 1'b1;
  logic          sec_clk     = 1'b0;
  logic          entry_req   = 1'b0;
  logic          exit_req    = 1'b0;
  logic          pass_sensor = 1'b0;
  logic          gate_open;
  logic [CW-1:0] occupancy;
  logic          full;
  logic          alarm;

  typedef struct {
    string tag;
    logic  gate;
    int    occ;
    logic  full;
    logic  alarm;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  parking_gate_ctrl dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sec_clk     (sec_clk),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .pass_sensor (pass_sensor),
    .gate_open   (gate_open),
    .occupancy   (occupancy),
    .full        (full),
    .alarm       (alarm)
  );

  always #12 clk_in = ~clk_in;

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic expect_out(input string tag, input logic g, input int occ, input logic f, input logic a);
    exp_t e;
    e.tag = tag; e.gate = g; e.occ = occ; e.full = f; e.alarm = a;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t          e;
    logic [CW+2:0] obs;
    logic [CW+2:0] want;
    e    = sb.pop_front();
    obs  = {gate_open, occupancy, full, alarm};
    want = {e.gate, CW'(e.occ), e.full, e.alarm};
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed gate=%b occ=%0d full=%b alarm=%b, expected gate=%b occ=%0d full=%b alarm=%b",
                e.tag, gate_open, occupancy, full, alarm, e.gate, e.occ, e.full, e.alarm);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      sec_clk = 1'b1;
      nclk(4);
      sec_clk = 1'b0;
      nclk(4);
    end
  endtask

  task automatic car_pass();
    pass_sensor = 1'b1;
    nclk(2);
    pass_sensor = 1'b0;
    nclk(2);
  endtask

  task automatic car_cycle(input bit is_exit);
    if (is_exit) exit_req = 1'b1;
    else         entry_req = 1'b1;
    nclk(1);
    exit_req  = 1'b0;
    entry_req = 1'b0;
    car_pass();
    ticks(HOLD);
    nclk(2);
  endtask

  initial begin
    int occ;
    nclk(3);
    expect_out("reset", 1'b0, 0, 1'b0, 1'b0);
    check_out();
    rst = 1'b0;
    nclk(2);

    // single entry: open next cycle, count on clear, close after 5 ticks
    entry_req = 1'b1;
    expect_out("entry_open_next_cycle", 1'b1, 0, 1'b0, 1'b0);
    nclk(1);
    check_out();
    entry_req = 1'b0;
    expect_out("entry_counted", 1'b1, 1, 1'b0, 1'b0);
    car_pass();
    check_out();
    expect_out("hold_after_4_ticks", 1'b1, 1, 1'b0, 1'b0);
    ticks(HOLD - 1);
    check_out();
    expect_out("closed_after_5_ticks", 1'b0, 1, 1'b0, 1'b0);
    ticks(1);
    nclk(2);
    check_out();

    // fill the lot, then try one more entry
    occ = 1;
    for (int i = 0; i < CAP - 1; i++) begin
      car_cycle(1'b0);
      occ++;
    end
    expect_out("lot_full", 1'b0, CAP, 1'b1, 1'b0);
    check_out();
    entry_req = 1'b1;
    expect_out("entry_refused_when_full", 1'b0, CAP, 1'b1, 1'b0);
    nclk(3);
    check_out();
    entry_req = 1'b0;
    nclk(1);
    expect_out("exit_from_full", 1'b0, CAP - 1, 1'b0, 1'b0);
    car_cycle(1'b1);
    check_out();

    // drain to 3, then simultaneous requests: exit must win
    for (int i = 0; i < CAP - 4; i++) car_cycle(1'b1);
    expect_out("drained_to_3", 1'b0, 3, 1'b0, 1'b0);
    check_out();
    entry_req = 1'b1;
    exit_req  = 1'b1;
    expect_out("both_req_opens", 1'b1, 3, 1'b0, 1'b0);
    nclk(1);
    check_out();
    entry_req = 1'b0;
    exit_req  = 1'b0;
    expect_out("exit_priority_dec", 1'b1, 2, 1'b0, 1'b0);
    car_pass();
    check_out();
    ticks(HOLD);
    nclk(2);

    // pass_sensor in HOLD with one tick left reloads the full hold time
    entry_req = 1'b1;
    nclk(1);
    entry_req = 1'b0;
    car_pass();
    ticks(HOLD - 1);
    expect_out("reload_keeps_open", 1'b1, 3, 1'b0, 1'b0);
    car_pass();
    ticks(HOLD - 1);
    check_out();
    expect_out("reload_then_close", 1'b0, 3, 1'b0, 1'b0);
    ticks(1);
    nclk(2);
    check_out();

    // exit at zero saturates
    for (int i = 0; i < 3; i++) car_cycle(1'b1);
    expect_out("exit_at_zero_saturates", 1'b0, 0, 1'b0, 1'b0);
    car_cycle(1'b1);
    check_out();

    // entry request with no car arriving
    entry_req = 1'b1;
    nclk(1);
    entry_req = 1'b0;
    expect_out("waiting_29_ticks", 1'b1, 0, 1'b0, 1'b0);
    ticks(TMO - 1);
    check_out();
`ifdef GATE_TIMEOUT_EN
    expect_out("timeout_alarm", 1'b1, 0, 1'b0, 1'b1);
    ticks(1);
    check_out();
    expect_out("timeout_gate_closed", 1'b0, 0, 1'b0, 1'b1);
    ticks(HOLD);
    nclk(2);
    check_out();
    entry_req = 1'b1;
    nclk(1);
    entry_req = 1'b0;
    expect_out("alarm_cleared_by_car", 1'b1, 1, 1'b0, 1'b0);
    car_pass();
    check_out();
`else
    expect_out("no_timeout_open", 1'b1, 0, 1'b0, 1'b0);
    ticks(1 + HOLD);
    check_out();
    expect_out("late_car_counted", 1'b1, 1, 1'b0, 1'b0);
    car_pass();
    check_out();
`endif
    ticks(HOLD);
    nclk(2);

    // reach 7 cars, reset asynchronously in HOLD
    for (int i = 0; i < 5; i++) car_cycle(1'b0);
    entry_req = 1'b1;
    nclk(1);
    entry_req = 1'b0;
    car_pass();
    ticks(2);
    expect_out("hold_before_reset", 1'b1, 7, 1'b0, 1'b0);
    check_out();
    #3;
    rst = 1'b1;
    #2;
    expect_out("async_reset_mid_hold", 1'b0, 0, 1'b0, 1'b0);
    check_out();
    nclk(2);
    rst = 1'b0;
    nclk(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
